pet_state_engine: RTL and testbench

PET_STATE_ENGINE -- requirements
Module: pet_state_engine

---
 rtl/pet_state_engine.sv | 157 +++++++++++++++
 tb/tb_pet_state_engine.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pet_state_engine.sv
// Virtual-pet state engine: need levels with decay, request cooldown and mood FSM.
// Optional test mode (faster decay, toggled by `test`) is built only when PET_TEST_MODE_EN is defined.
module pet_state_engine #(
   parameter int NUM_NEEDS  = 5,
   parameter int DECAY_S    = 10,
   parameter int COOLDOWN_S = 3,
   parameter int CRIT_S     = 20,
   parameter int TEST_DIV   = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick_1s,
   input  logic                   req_valid,
   input  logic [2:0]             req_state,
   input  logic                   req_up,
   input  logic                   req_down,
   input  logic                   test,
   output logic                   req_ready,
   output logic [3*NUM_NEEDS-1:0] levels,
   output logic [1:0]             mood,
   output logic                   test_mode
);

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      ALERT    = 2'd1,
      CRITICAL = 2'd2,
      DEAD     = 2'd3
   } mood_t;

   localparam int DW          = $clog2(DECAY_S + 1);
   localparam int CW          = $clog2(COOLDOWN_S + 1);
   localparam int KW          = $clog2(CRIT_S + 1);
   localparam int TEST_PERIOD = (DECAY_S / TEST_DIV < 1) ? 1 : DECAY_S / TEST_DIV;
   localparam int FOOD        = 0;
   localparam int HEALTH      = (NUM_NEEDS > 4) ? 4 : NUM_NEEDS - 1;

   logic [2:0]    lvl_q [NUM_NEEDS];
   logic [2:0]    lvl_d [NUM_NEEDS];
   mood_t         mood_q, mood_d;
   logic [DW-1:0] dec_cnt_q;
   logic [DW-1:0] dec_last;
   logic [CW-1:0] cd_cnt_q;
   logic          cd_active_q;
   logic [KW-1:0] crit_cnt_q;
   logic          test_mode_q;
   logic          dead, accept, req_ok, eff_up, eff_down, decay_step;

   assign dead     = (mood_q == DEAD);
   assign accept   = req_valid && req_ready;
   assign req_ok   = accept && (req_up ^ req_down) && (int'(req_state) < NUM_NEEDS);
   assign eff_up   = req_ok && req_up;
   assign eff_down = req_ok && req_down;

`ifdef PET_TEST_MODE_EN
   always_ff @(posedge clk) begin
      if (rst)       test_mode_q <= 1'b0;
      else if (test) test_mode_q <= ~test_mode_q;
   end
   assign dec_last = test_mode_q ? DW'(TEST_PERIOD - 1) : DW'(DECAY_S - 1);
`else
   wire unused_test = test;
   assign test_mode_q = 1'b0;
   assign dec_last    = DW'(DECAY_S - 1);
`endif

   // >= rather than == so a test-mode toggle mid-period cannot skip past the terminal count
   assign decay_step = tick_1s && !dead && (dec_cnt_q >= dec_last);

   // Decay is applied before the request, so a coinciding up on level 0 still lands at 1
   always_comb begin
      logic [2:0] v;
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      v = '0;
      for (int i = 0; i < NUM_NEEDS; i++) begin
         v = lvl_q[i];
         if (decay_step && v != 3'd0) v = v - 3'd1;
         if (int'(req_state) == i) begin
            if (eff_up && v != 3'd7)   v = v + 3'd1;
            if (eff_down && v != 3'd0) v = v - 3'd1;
         end
         lvl_d[i] = v;
      end
   end

   // NOTE: the level array is a handful of flops, not a RAM, so it takes a real reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEEDS; i++) lvl_q[i] <= 3'd4;
      end else if (!dead) begin
         for (int i = 0; i < NUM_NEEDS; i++) lvl_q[i] <= lvl_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_cnt_q   <= '0;
         cd_active_q <= 1'b0;
         cd_cnt_q    <= '0;
         crit_cnt_q  <= '0;
      end else if (!dead) begin
         if (decay_step)   dec_cnt_q <= '0;
         else if (tick_1s) dec_cnt_q <= dec_cnt_q + 1'b1;

         if (eff_up) begin
            cd_active_q <= 1'b1;
            cd_cnt_q    <= '0;
         end else if (cd_active_q && tick_1s) begin
            if (cd_cnt_q == CW'(COOLDOWN_S - 1)) begin
               cd_active_q <= 1'b0;
               cd_cnt_q    <= '0;
            end else begin
               cd_cnt_q <= cd_cnt_q + 1'b1;
            end
         end

         if (mood_q != CRITICAL) crit_cnt_q <= '0;
         else if (tick_1s)       crit_cnt_q <= crit_cnt_q + 1'b1;
      end
   end

   // Mood FSM: state register
   always_ff @(posedge clk) begin
      if (rst) mood_q <= NORMAL;
      else     mood_q <= mood_d;
   end

   // Mood FSM: next state, derived from the current (registered) levels
   always_comb begin
      logic any_low;
      any_low = 1'b0;
      for (int i = 0; i < NUM_NEEDS; i++)
         if (lvl_q[i] <= 3'd2) any_low = 1'b1;

      mood_d = mood_q;
      if (mood_q == DEAD)
         mood_d = DEAD;
      else if (mood_q == CRITICAL && tick_1s && crit_cnt_q == KW'(CRIT_S - 1))
         mood_d = DEAD;
      else if (lvl_q[FOOD] == 3'd0 || lvl_q[HEALTH] == 3'd0)
         mood_d = CRITICAL;
      else if (any_low)
         mood_d = ALERT;
      else
         mood_d = NORMAL;
   end

   // Mood FSM: outputs
   always_comb begin
      levels = '0;
      for (int i = 0; i < NUM_NEEDS; i++) levels[3*i +: 3] = lvl_q[i];
      req_ready = !dead && !cd_active_q;
      mood      = mood_q;
      test_mode = test_mode_q;
   end

endmodule

// File: tb/tb_pet_state_engine.sv
// Directed self-checking bench for pet_state_engine; inputs change and outputs are sampled on negedge.
// Test-mode expectations follow PET_TEST_MODE_EN when it is defined for the build.
module tb_pet_state_engine;

   logic        clk = 1'b0;
   logic        rst, tick_1s, req_valid, req_up, req_down, test;
   logic [2:0]  req_state;
   logic        req_ready, test_mode;
   logic [14:0] levels;
   logic [1:0]  mood;

   int n_cmp = 0;
   int n_err = 0;

   pet_state_engine dut (
      .clk       (clk),
      .rst       (rst),
      .tick_1s   (tick_1s),
      .req_valid (req_valid),
      .req_state (req_state),
      .req_up    (req_up),
      .req_down  (req_down),
      .test      (test),
      .req_ready (req_ready),
      .levels    (levels),
      .mood      (mood),
      .test_mode (test_mode)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_req(input logic [2:0] st, input logic up, input logic dn);
      req_valid = 1'b1; req_state = st; req_up = up; req_down = dn;
      @(negedge clk);
      req_valid = 1'b0; req_up = 1'b0; req_down = 1'b0;
   endtask

   task automatic tick();
      tick_1s = 1'b1;
      @(negedge clk);
      tick_1s = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (levels !== 15'o44444) begin n_err++; $display("FAIL reset_levels: got %o want %o", levels, 15'o44444); end
      n_cmp++; if (mood !== 2'd0)        begin n_err++; $display("FAIL reset_mood: got %0d want 0", mood); end
      n_cmp++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      n_cmp++; if (test_mode !== 1'b0)   begin n_err++; $display("FAIL reset_test_mode: got %b want 0", test_mode); end
   endtask

   task automatic test_cooldown();
      apply_reset();
      do_req(3'd0, 1'b1, 1'b0);
      n_cmp++; if (levels[2:0] !== 3'd5) begin n_err++; $display("FAIL up_food: got %0d want 5", levels[2:0]); end
      n_cmp++; if (req_ready !== 1'b0)   begin n_err++; $display("FAIL cd_start: got %b want 0", req_ready); end
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_cmp++;
         if (req_ready !== (k == 3)) begin
            n_err++; $display("FAIL cd_tick%0d: got %b want %b", k, req_ready, (k == 3));
         end
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         do_req(3'd4, 1'b1, 1'b0);
         repeat (3) tick();
      end
      n_cmp++; if (levels[14:12] !== 3'd7) begin n_err++; $display("FAIL health_to_7: got %0d want 7", levels[14:12]); end
      do_req(3'd4, 1'b1, 1'b0);
      n_cmp++; if (levels[14:12] !== 3'd7) begin n_err++; $display("FAIL health_sat7: got %0d want 7", levels[14:12]); end

      apply_reset();
      repeat (5) do_req(3'd0, 1'b0, 1'b1);
      n_cmp++; if (levels !== 15'o44440) begin n_err++; $display("FAIL food_sat0: got %o want %o", levels, 15'o44440); end
      n_cmp++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL down_no_cd: got %b want 1", req_ready); end
      @(negedge clk);
      n_cmp++; if (mood !== 2'd2)        begin n_err++; $display("FAIL food0_crit: got %0d want 2", mood); end
   endtask

   task automatic test_decay_and_death();
      apply_reset();
      repeat (10) tick();
      n_cmp++; if (levels !== 15'o33333) begin n_err++; $display("FAIL decay10: got %o want %o", levels, 15'o33333); end
      n_cmp++; if (mood !== 2'd0)        begin n_err++; $display("FAIL decay10_mood: got %0d want 0", mood); end
      repeat (20) tick();
      n_cmp++; if (levels !== 15'o11111) begin n_err++; $display("FAIL decay30: got %o want %o", levels, 15'o11111); end
      n_cmp++; if (mood !== 2'd1)        begin n_err++; $display("FAIL decay30_mood: got %0d want 1", mood); end
      repeat (10) tick();
      n_cmp++; if (levels !== 15'o00000) begin n_err++; $display("FAIL decay40: got %o want 0", levels); end
      @(negedge clk);
      n_cmp++; if (mood !== 2'd2)        begin n_err++; $display("FAIL crit_mood: got %0d want 2", mood); end
      repeat (19) tick();
      n_cmp++; if (mood !== 2'd2)        begin n_err++; $display("FAIL crit19: got %0d want 2", mood); end
      tick();
      n_cmp++; if (mood !== 2'd3)        begin n_err++; $display("FAIL dead: got %0d want 3", mood); end
      n_cmp++; if (req_ready !== 1'b0)   begin n_err++; $display("FAIL dead_ready: got %b want 0", req_ready); end
      do_req(3'd0, 1'b1, 1'b0);
      repeat (10) tick();
      n_cmp++; if (levels !== 15'o00000) begin n_err++; $display("FAIL dead_frozen: got %o want 0", levels); end
      n_cmp++; if (mood !== 2'd3)        begin n_err++; $display("FAIL dead_hold: got %0d want 3", mood); end
      apply_reset();
      n_cmp++; if (levels !== 15'o44444) begin n_err++; $display("FAIL revive_levels: got %o want %o", levels, 15'o44444); end
      n_cmp++; if (mood !== 2'd0)        begin n_err++; $display("FAIL revive_mood: got %0d want 0", mood); end
      n_cmp++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL revive_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_coincide();
      apply_reset();
      do_req(3'd2, 1'b0, 1'b1);
      repeat (9) tick();
      n_cmp++; if (levels !== 15'o44344) begin n_err++; $display("FAIL pre_coincide: got %o want %o", levels, 15'o44344); end
      tick_1s = 1'b1; req_valid = 1'b1; req_state = 3'd2; req_up = 1'b1; req_down = 1'b0;
      @(negedge clk);
      tick_1s = 1'b0; req_valid = 1'b0; req_up = 1'b0;
      n_cmp++; if (levels !== 15'o33333) begin n_err++; $display("FAIL coincide: got %o want %o", levels, 15'o33333); end
      n_cmp++; if (req_ready !== 1'b0)   begin n_err++; $display("FAIL coincide_cd: got %b want 0", req_ready); end
   endtask

   task automatic test_noop();
      apply_reset();
      do_req(3'd6, 1'b1, 1'b0);
      n_cmp++; if (levels !== 15'o44444) begin n_err++; $display("FAIL bad_index_lvl: got %o want %o", levels, 15'o44444); end
      n_cmp++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL bad_index_rdy: got %b want 1", req_ready); end
      do_req(3'd1, 1'b1, 1'b1);
      do_req(3'd1, 1'b0, 1'b0);
      n_cmp++; if (levels !== 15'o44444) begin n_err++; $display("FAIL updown_noop: got %o want %o", levels, 15'o44444); end
      n_cmp++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL updown_rdy: got %b want 1", req_ready); end
   endtask

   task automatic test_test_mode();
      apply_reset();
      test = 1'b1;
      @(negedge clk);
      test = 1'b0;
      repeat (2) tick();
`ifdef PET_TEST_MODE_EN
      n_cmp++; if (test_mode !== 1'b1)   begin n_err++; $display("FAIL tm_on: got %b want 1", test_mode); end
      n_cmp++; if (levels !== 15'o33333) begin n_err++; $display("FAIL tm_decay: got %o want %o", levels, 15'o33333); end
`else
      n_cmp++; if (test_mode !== 1'b0)   begin n_err++; $display("FAIL tm_off: got %b want 0", test_mode); end
      n_cmp++; if (levels !== 15'o44444) begin n_err++; $display("FAIL tm_nodecay: got %o want %o", levels, 15'o44444); end
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tick_1s = 1'b0; req_valid = 1'b0; req_state = 3'd0;
      req_up = 1'b0; req_down = 1'b0; test = 1'b0;
      @(negedge clk);
      test_reset();
      test_cooldown();
      test_saturation();
      test_decay_and_death();
      test_coincide();
      test_noop();
      test_test_mode();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
